// File: rtl/lut_probe_pkg.sv
// Shared types and helpers for the LUT prober: FSM state encoding, last probe
// index and the index-to-drive mapping.
package lut_probe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_CONFIRM,
        ST_DONE
    } probe_state_t;

    localparam logic [1:0] IDX_LAST = 2'd3;

    // idx[1] drives a, idx[0] drives b
    function automatic logic [1:0] idx_to_ab(input logic [1:0] idx);
        return {idx[1], idx[0]};
    endfunction

endpackage

// File: rtl/lut_prober_if.sv
// Control and probe signals of the LUT prober. LUT_PROBE_CHECK_EN adds the
// expected_func / mismatch pair.
interface lut_prober_if;
    logic       start;
    logic       busy;
    logic       done;
    logic       a;
    logic       b;
    logic       lut_out;
    logic [3:0] func;
    logic       unstable;
`ifdef LUT_PROBE_CHECK_EN
    logic [3:0] expected_func;
    logic       mismatch;

    modport master (
        output start, lut_out, expected_func,
        input  busy, done, a, b, func, unstable, mismatch
    );
    modport slave (
        input  start, lut_out, expected_func,
        output busy, done, a, b, func, unstable, mismatch
    );
`else
    modport master (
        output start, lut_out,
        input  busy, done, a, b, func, unstable
    );
    modport slave (
        input  start, lut_out,
        output busy, done, a, b, func, unstable
    );
`endif
endinterface

// File: rtl/probe_settle_timer.sv
// Loadable down-counter that measures the settle interval; expired is high
// during the last settle cycle.
module probe_settle_timer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [W-1:0] LOAD_VAL = W'(SETTLE_CYCLES);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= LOAD_VAL;
        end else if (en && cnt_reg != '0) begin
            cnt_reg <= cnt_reg - W'(1);
        end
    end

    assign expired = (cnt_reg == W'(1));
endmodule

// File: rtl/lut_prober.sv
// Sequential prober that reads back the 4-bit function of a 2-input logic unit.
// Optional expected-function compare is enabled with LUT_PROBE_CHECK_EN.
module lut_prober
    import lut_probe_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    lut_prober_if.slave  pif
);
    probe_state_t state_reg;
    logic [1:0]   idx_reg;
    logic [3:0]   shadow_reg;
    logic         s0_reg;
    logic         acc_reg;
    logic         busy_reg;
    logic         done_reg;
    logic [1:0]   ab_reg;
    logic [3:0]   func_reg;
    logic         unstable_reg;

    logic       timer_load;
    logic       timer_en;
    logic       timer_expired;
    logic       sample_diff;
    logic [3:0] shadow_final;

    assign timer_load = (state_reg == ST_IDLE && pif.start) ||
                        (state_reg == ST_CONFIRM && idx_reg != IDX_LAST);
    assign timer_en   = (state_reg == ST_SETTLE);

    probe_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (timer_load),
        .en      (timer_en),
        .expired (timer_expired)
    );

    // Second sample is compared live against the first; it needs no register.
    assign sample_diff = (s0_reg != pif.lut_out);

    // Results are registered on the edge into DONE so they are already valid
    // while done is high; this folds in the last index being written.
    always_comb begin
        shadow_final           = shadow_reg;
        shadow_final[IDX_LAST] = s0_reg;
    end

`ifdef LUT_PROBE_CHECK_EN
    logic mismatch_reg;
    assign pif.mismatch = mismatch_reg;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            idx_reg      <= 2'd0;
            shadow_reg   <= 4'b0000;
            s0_reg       <= 1'b0;
            acc_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            ab_reg       <= 2'b00;
            func_reg     <= 4'b0000;
            unstable_reg <= 1'b0;
`ifdef LUT_PROBE_CHECK_EN
            mismatch_reg <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (pif.start) begin
                        idx_reg    <= 2'd0;
                        shadow_reg <= 4'b0000;
                        acc_reg    <= 1'b0;
                        busy_reg   <= 1'b1;
                        ab_reg     <= idx_to_ab(2'd0);
                        state_reg  <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (timer_expired) begin
                        state_reg <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    s0_reg    <= pif.lut_out;
                    state_reg <= ST_CONFIRM;
                end
                ST_CONFIRM: begin
                    shadow_reg[idx_reg] <= s0_reg;
                    if (sample_diff) begin
                        acc_reg <= 1'b1;
                    end
                    if (idx_reg == IDX_LAST) begin
                        busy_reg     <= 1'b0;
                        done_reg     <= 1'b1;
                        func_reg     <= shadow_final;
                        unstable_reg <= acc_reg | sample_diff;
`ifdef LUT_PROBE_CHECK_EN
                        mismatch_reg <= (shadow_final != pif.expected_func);
`endif
                        state_reg    <= ST_DONE;
                    end else begin
                        idx_reg   <= idx_reg + 2'd1;
                        ab_reg    <= idx_to_ab(idx_reg + 2'd1);
                        state_reg <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    ab_reg    <= 2'b00;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign pif.busy     = busy_reg;
    assign pif.done     = done_reg;
    assign pif.a        = ab_reg[1];
    assign pif.b        = ab_reg[0];
    assign pif.func     = func_reg;
    assign pif.unstable = unstable_reg;
endmodule

// File: tb/tb_lut_prober.sv
// Bench for lut_prober: two instances (settle 1 and 3) probing a modelled
// logic unit with selectable output latency; covers LUT_PROBE_CHECK_EN when set.
module tb_lut_prober;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lut_prober_if if1 ();
    lut_prober_if if3 ();

    lut_prober #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .pif(if1.slave));
    lut_prober #(.SETTLE_CYCLES(3)) dut3 (.clk(clk), .rst_n(rst_n), .pif(if3.slave));

    // Unit under probe models: combinational, or 1/2 cycles of registered latency
    logic [3:0] unit_func1, unit_func3;
    int         lat1, lat3;
    logic       p1a, p1b, p3a, p3b;
    logic       flip1;

    always @(posedge clk) begin
        p1a <= unit_func1[{if1.a, if1.b}];
        p1b <= p1a;
        p3a <= unit_func3[{if3.a, if3.b}];
        p3b <= p3a;
    end

    assign if1.lut_out = ((lat1 == 0) ? unit_func1[{if1.a, if1.b}] :
                          (lat1 == 1) ? p1a : p1b) ^ flip1;
    assign if3.lut_out = (lat3 == 0) ? unit_func3[{if3.a, if3.b}] :
                         (lat3 == 1) ? p3a : p3b;

    int cur_sel = 1;
    wire       cur_done = (cur_sel == 3) ? if3.done     : if1.done;
    wire       cur_busy = (cur_sel == 3) ? if3.busy     : if1.busy;
    wire       cur_a    = (cur_sel == 3) ? if3.a        : if1.a;
    wire       cur_b    = (cur_sel == 3) ? if3.b        : if1.b;
    wire [3:0] cur_func = (cur_sel == 3) ? if3.func     : if1.func;
    wire       cur_uns  = (cur_sel == 3) ? if3.unstable : if1.unstable;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] f;
        logic       u;
        int         lat;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [3:0] unit;
        int         lat;
        logic [3:0] ef;
        logic       eu;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (cur_sel == 3) if3.start = v;
        else              if1.start = v;
    endtask

    // One probe run; expectation is queued at start and popped at done.
    task automatic run_probe(input int sel, input logic [3:0] unit, input int lat,
                             input logic [3:0] exp_f, input logic exp_u,
                             input bit do_flip, input bit do_extra);
        exp_t e;
        int   s;
        int   n;
        int   dones;
        logic [1:0] k;
        cur_sel = sel;
        s = (sel == 3) ? 3 : 1;
        if (sel == 3) begin unit_func3 = unit; lat3 = lat; end
        else          begin unit_func1 = unit; lat1 = lat; end
        repeat (4) @(negedge clk);
        e.f = exp_f; e.u = exp_u; e.lat = 4 * (s + 2);
        exp_q.push_back(e);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        n = 0;
        while (!cur_done && n < 200) begin
            k = 2'(n / (s + 2));
            check("ab_drive", {30'd0, cur_a, cur_b}, {30'd0, k});
            check("busy_run", {31'd0, cur_busy}, 32'd1);
            flip1 = (do_flip && n == 2 * (s + 2) + s + 1);
            if (do_extra) set_start(n == 4);
            @(negedge clk);
            n++;
        end
        flip1 = 1'b0;
        if (exp_q.size() == 0) begin
            check("queue_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("latency", n, e.lat);
            check("func", {28'd0, cur_func}, {28'd0, e.f});
            check("unstable", {31'd0, cur_uns}, {31'd0, e.u});
        end
        check("busy_at_done", {31'd0, cur_busy}, 32'd0);
        $display("run sel=%0d unit=%b lat=%0d -> func=%b unstable=%0d edges=%0d",
                 sel, unit, lat, cur_func, cur_uns, n);
        if (do_extra) set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        check("done_pulse", {31'd0, cur_done}, 32'd0);
        if (do_extra) begin
            dones = 0;
            repeat (15) begin
                @(negedge clk);
                if (cur_done) dones++;
                check("no_restart_busy", {31'd0, cur_busy}, 32'd0);
            end
            check("extra_done", dones, 0);
        end
    endtask

    initial begin
        int n;
        int dones;
        // XOR, AND, NOR, OR, constants, then a 1-latency and 2-latency unit
        vecs[0] = '{4'b0110, 0, 4'b0110, 1'b0};
        vecs[1] = '{4'b1000, 0, 4'b1000, 1'b0};
        vecs[2] = '{4'b0001, 0, 4'b0001, 1'b0};
        vecs[3] = '{4'b1110, 0, 4'b1110, 1'b0};
        vecs[4] = '{4'b1111, 0, 4'b1111, 1'b0};
        vecs[5] = '{4'b0000, 0, 4'b0000, 1'b0};
        vecs[6] = '{4'b1110, 1, 4'b1110, 1'b0};
        // settle too short for 2-cycle latency: each index reads its predecessor
        vecs[7] = '{4'b1110, 2, 4'b1100, 1'b1};

        rst_n = 1'b0;
        if1.start = 1'b0; if3.start = 1'b0;
        unit_func1 = 4'b0000; unit_func3 = 4'b0000;
        lat1 = 0; lat3 = 0; flip1 = 1'b0;
`ifdef LUT_PROBE_CHECK_EN
        if1.expected_func = 4'b0000;
        if3.expected_func = 4'b0000;
`endif
        repeat (3) @(negedge clk);
        check("reset_out1", {24'd0, if1.busy, if1.done, if1.a, if1.b, if1.func, if1.unstable}, 32'd0);
        check("reset_out3", {24'd0, if3.busy, if3.done, if3.a, if3.b, if3.func, if3.unstable}, 32'd0);
`ifdef LUT_PROBE_CHECK_EN
        check("reset_mismatch", {31'd0, if1.mismatch}, 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_probe(1, vecs[i].unit, vecs[i].lat, vecs[i].ef, vecs[i].eu, 1'b0, 1'b0);
        end

        run_probe(3, 4'b1110, 1, 4'b1110, 1'b0, 1'b0, 1'b0);
        run_probe(3, 4'b0110, 0, 4'b0110, 1'b0, 1'b0, 1'b0);

        // Toggle during index 2, then a clean run clears unstable
        run_probe(1, 4'b0110, 0, 4'b0110, 1'b1, 1'b1, 1'b0);
        run_probe(1, 4'b0110, 0, 4'b0110, 1'b0, 1'b0, 1'b0);

        // start pulses mid-run and during DONE are ignored
        run_probe(1, 4'b1000, 0, 4'b1000, 1'b0, 1'b0, 1'b1);

        // start held high: restart on the first IDLE cycle after DONE
        cur_sel = 1; unit_func1 = 4'b0110; lat1 = 0;
        repeat (4) @(negedge clk);
        set_start(1'b1);
        n = 0;
        do begin @(negedge clk); n++; end while (!cur_done && n < 200);
        check("b2b_first", n, 13);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 2) set_start(1'b0);
        end while (!cur_done && n < 200);
        set_start(1'b0);
        check("b2b_gap", n, 14);
        check("b2b_func", {28'd0, cur_func}, 32'h6);
        $display("run back-to-back gap=%0d func=%b", n, cur_func);
        @(negedge clk);

`ifdef LUT_PROBE_CHECK_EN
        if1.expected_func = 4'b0110;
        run_probe(1, 4'b0111, 0, 4'b0111, 1'b0, 1'b0, 1'b0);
        check("mismatch_set", {31'd0, if1.mismatch}, 32'd1);
        run_probe(1, 4'b0110, 0, 4'b0110, 1'b0, 1'b0, 1'b0);
        check("mismatch_clear", {31'd0, if1.mismatch}, 32'd0);
`endif

        // Reset in cycle T+6 of a run clears everything and suppresses done
        run_probe(1, 4'b0110, 0, 4'b0110, 1'b0, 1'b0, 1'b0);
        cur_sel = 1;
        repeat (2) @(negedge clk);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        n = 0;
        while (n < 5) begin @(negedge clk); n++; end
        rst_n = 1'b0;
        @(negedge clk);
        check("midrun_reset", {24'd0, if1.busy, if1.done, if1.a, if1.b, if1.func, if1.unstable}, 32'd0);
`ifdef LUT_PROBE_CHECK_EN
        check("midrun_reset_mm", {31'd0, if1.mismatch}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (if1.done) dones++;
        end
        check("reset_no_done", dones, 0);
        $display("run reset mid-run func=%b busy=%0d", if1.func, if1.busy);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lut_prober.md
# lut_prober

Sequential prober for a 2-input programmable logic unit (`out = func[{a,b}]`). It walks all four input combinations, drives `a`/`b` into the unit under probe, waits a configurable settle time, samples the unit's output twice, and reassembles the 4-bit `func` code the unit implements. It is the inverse of the logical unit: it reads a function back from the outputs instead of applying one. Used for self-test and bring-up of logic-unit instances.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 1: cycles between driving `a`/`b` and the first sample. Legal range 1..255.

Ports:
- `clk`  in  1  system clock; all logic rising-edge.
- `rst_n`  in  1  **One clock; reset is synchronous and active-low.**
- `start`  in  1  start request; accepted only in IDLE.
- `busy`  out  1  high from the cycle after acceptance through the last CONFIRM cycle.
- `done`  out  1  one-cycle pulse; `func`/`unstable` valid and held from this cycle.
- `a`  out  1  probe drive, `= idx[1]`.
- `b`  out  1  probe drive, `= idx[0]`.
- `lut_out`  in  1  output of the unit under probe.
- `func`  out  4  recovered code; `func[i]` = output observed for `{a,b}=i`.
- `unstable`  out  1  set if any index gave differing samples in the run.

## Operation
- FSM states: IDLE, SETTLE, SAMPLE, CONFIRM, DONE.
- IDLE: `a=b=0`. On `start=1`: `idx<=0`, clear shadow and unstable accumulator, go to SETTLE.
- SETTLE: drive `{a,b}=idx`, count SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE: capture `lut_out` into `s0`. Next state is CONFIRM.
- CONFIRM: capture `s1=lut_out` and write `shadow[idx]<=s0`. Set the accumulator if `s0!=s1`. If `idx==3`, go to DONE. Otherwise `idx<=idx+1` and go to SETTLE.
- DONE: `func<=shadow`, `unstable<=acc`, `done=1` for exactly one cycle. Next state is IDLE.
- `func` and `unstable` keep the previous result throughout a run. They update only on the DONE cycle.
- `start` is ignored in SETTLE, SAMPLE, CONFIRM and DONE. It is neither queued nor restarting.
- `idx` is a 2-bit value and never wraps past 3 within a run.

## Timing
- Reset values: `busy=0`, `done=0`, `a=0`, `b=0`, `func=4'b0000`, `unstable=0`. FSM goes to IDLE.
- Cycle budget for start accepted at edge T:
  - Each index takes SETTLE_CYCLES+2 cycles.
  - `done` is high during cycle T+1+4*(SETTLE_CYCLES+2). With SETTLE_CYCLES=1 that is T+13.
- Back-to-back runs: `start` held high restarts in the first IDLE cycle after DONE.
- `a`/`b` change only when entering SETTLE. They are stable through SAMPLE and CONFIRM.
- `rst_n=0` mid-run: all outputs return to reset values at the next edge, and no `done` is issued.

## Configuration
- `LUT_PROBE_CHECK_EN` defined:
  - Adds input `expected_func[3:0]` and output `mismatch` (1 bit, reset 0).
  - `mismatch<=(shadow!=expected_func)` on the DONE cycle, held until the next DONE.
  - `expected_func` is sampled on the DONE cycle.
- Not defined: neither port exists, and the block is otherwise identical.

## Structure
- Package `lut_probe_pkg`:
  - FSM state enum `probe_state_t`.
  - Constant `IDX_LAST = 2'd3`.
  - Function `idx_to_ab(idx)` returning `{a,b}`.
- One sub-module, `probe_settle_timer`:
  - Loadable down-counter, width `$clog2(SETTLE_CYCLES+1)`.
  - Inputs `load`, `en`. Output `expired`.
  - Same clock and reset.
- Top holds the FSM, `idx`, shadow, `s0`, accumulator and output registers.

## Test plan
- Probed unit set to XOR (`func=4'b0110`), SETTLE_CYCLES=1, `start` pulse at T -> `done` at T+13, `func=4'b0110`, `unstable=0`. Reaches the same result with AND `4'b1000` and NOR `4'b0001`.
- SETTLE_CYCLES=3, unit with one cycle of registered latency, `func=4'b1110` -> `done` at T+21, `func=4'b1110`. Repeating with SETTLE_CYCLES=1 and a 2-cycle-latency unit gives a wrong `func`, which is expected.
- Force `lut_out` to toggle between SAMPLE and CONFIRM of index 2 -> `unstable=1` at `done`. The next clean run gives `unstable=0`.
- `start` pulsed again at T+5 and during the DONE cycle -> exactly one `done`, at T+13. `busy` stays continuous with no restart.
- `rst_n=0` at T+6 -> next cycle all outputs are 0, no `done` appears, and the previous `func` is cleared to 0.
- With `LUT_PROBE_CHECK_EN`, `expected_func=4'b0110` and unit `4'b0111` -> `mismatch=1` at `done`. Rerunning with a matching unit clears it to 0.
